fifo32_sdp_ctrl: RTL and testbench
==================================

FIFO32_SDP_CTRL -- requirements
Module: fifo32_sdp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 6: data width in bits, range 1..36.
REQ-002 SHALL have parameter AFULL_LVL, default 28: almost_full threshold, range 1..32.
REQ-003 SHALL have port clk, input, 1: single clock for all logic and for the RAM write clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1: synchronous clear of all contents.
REQ-006 SHALL have port in_valid, input, 1: upstream word present.
REQ-007 SHALL have port in_data, input, WIDTH: upstream word.
REQ-008 SHALL have port in_ready, output, 1: the block accepts in_data this cycle.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a word.
REQ-010 SHALL have port out_data, output, WIDTH: registered head-of-queue word.
REQ-011 SHALL have port out_ready, input, 1: downstream consumes this cycle.
REQ-012 SHALL have port level, output, 6: RAM occupancy plus out_valid, range 0..33.
REQ-013 SHALL have port almost_full, output, 1: registered, high when RAM occupancy >= AFULL_LVL.
REQ-014 SHALL have port ovf, output, 1: sticky flag for an in_valid attempt while in_ready is low.

Function
REQ-015 SHALL instantiate one 32-entry simple-dual-port distributed RAM (ram32xsdp, WIDTH passed through): write on clk when we is high, asynchronous read at raddr.
REQ-016 SHALL keep wr_ptr and rd_ptr as 6-bit counters: bits [4:0] drive the RAM addresses, bit 5 is the wrap bit.
REQ-017 SHALL compute RAM occupancy as wr_ptr - rd_ptr modulo 64, range 0..32.
REQ-018 SHALL set empty when the pointers are equal, and full when [4:0] are equal and bit 5 differs.
REQ-019 SHALL drive in_ready = !full; it is combinational from registered pointers, with no dependence on in_valid.
REQ-020 SHALL perform a push when in_valid && in_ready: RAM we=1 at waddr=wr_ptr[4:0], and wr_ptr increments on that edge.
REQ-021 SHALL load the output register on a clock edge when (!out_valid || out_ready) && !empty: out_data <= RAM[rd_ptr], rd_ptr increments, out_valid <= 1.
REQ-022 SHALL clear out_valid on an edge where out_valid && out_ready && empty.
REQ-023 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL have the following latency: a word pushed at edge k into an empty block with out_valid=0 appears with out_valid=1 after edge k+1; a word is never read in the same edge it is written.
REQ-025 SHALL, on simultaneous push and prefetch, use the pre-edge values of both pointers; occupancy is unchanged.
REQ-026 SHALL, when full and a prefetch occurs, keep in_ready low in that cycle; in_ready rises after the edge.
REQ-027 SHALL wrap the pointers modulo 64 without any special handling.
REQ-028 SHALL set ovf on an edge where in_valid && !in_ready; ovf clears only on reset or flush.
REQ-029 SHALL, on flush (highest priority over push and pop), set wr_ptr=rd_ptr=0, out_valid=0 and ovf=0; in_ready is still driven by the pre-edge state during the flush cycle.
REQ-030 SHALL register level and almost_full, updated each edge from the next-state values.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force wr_ptr=0, rd_ptr=0, out_valid=0, out_data=0, level=0, almost_full=0 and ovf=0; in_ready is then 1.
REQ-032 SHALL leave RAM contents undefined after reset; RAM contents are never observable without a push.
REQ-033 SHALL, when reset is asserted mid-transfer, discard all contents; the first push after rst_n rises behaves as into an empty block.

Verification
REQ-034 Push 0x15 at edge 1 with out_ready=0 -> out_valid=1 and out_data=0x15 after edge 2, level=1, then held stable.
REQ-035 Push 40 words 0..39 back-to-back with out_ready=0 -> 33 accepted (0..32), in_ready=0 from then on, level=33, ovf=1; then draining with out_ready=1 returns 0..32 in order, one per cycle.
REQ-036 Continuous push and pop of 100 words with out_ready=1 -> output is an ordered 0..99 stream, level stays at 1 or 2, and the pointers wrap past 63 without error.
REQ-037 Fill RAM to 28 entries -> almost_full=1 on the edge reaching 28; pop to 27 -> almost_full=0.
REQ-038 Assert flush with level=10 and in_valid=1 -> next cycle level=0, out_valid=0, ovf=0, and the flush-cycle word is dropped.
REQ-039 Assert rst_n=0 asynchronously mid-stream with level=5 -> outputs take reset values immediately; after release, push 0x2A -> out_data=0x2A two edges later.

Source files
------------

// File: rtl/fifo32_sdp_ctrl.sv
// 32-deep first-word-fall-through FIFO built on a simple-dual-port distributed RAM,
// with a registered output stage, registered level/almost_full and a sticky overflow flag.

module ram32xsdp #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [4:0]       raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [0:31];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

module fifo32_sdp_ctrl #(
   parameter int WIDTH     = 6,
   parameter int AFULL_LVL = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [5:0]       level,
   output logic             almost_full,
   output logic             ovf
);
   localparam logic [5:0] AFULL_THR = 6'(AFULL_LVL);

   logic [5:0]       wr_ptr_q, wr_ptr_d;
   logic [5:0]       rd_ptr_q, rd_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [5:0]       level_q, level_d;
   logic             afull_q, afull_d;
   logic             ovf_q, ovf_d;

   logic             empty, full, push, load;
   logic [5:0]       occ_d;
   logic [WIDTH-1:0] ram_rdata;

   // Handshake: a word moves on any edge where valid && ready are both high;
   // in_ready depends only on registered pointers, never on in_valid.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[4:0] == rd_ptr_q[4:0]) && (wr_ptr_q[5] != rd_ptr_q[5]);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign load     = (!out_valid_q || out_ready) && !empty;

   ram32xsdp #(.WIDTH(WIDTH)) u_ram (
      .clk   (clk),
      .we    (push && !flush),
      .waddr (wr_ptr_q[4:0]),
      .wdata (in_data),
      .raddr (rd_ptr_q[4:0]),
      .rdata (ram_rdata)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ovf_d       = ovf_q;
      if (flush) begin
         wr_ptr_d    = 6'd0;
         rd_ptr_d    = 6'd0;
         out_valid_d = 1'b0;
         ovf_d       = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 6'd1;
         // The read uses the pre-edge rd_ptr, so a word written this edge is never read this edge.
         if (load) begin
            rd_ptr_d    = rd_ptr_q + 6'd1;
            out_data_d  = ram_rdata;
            out_valid_d = 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
         if (in_valid && !in_ready) ovf_d = 1'b1;
      end
      occ_d   = wr_ptr_d - rd_ptr_d;
      level_d = occ_d + {5'd0, out_valid_d};
      afull_d = (occ_d >= AFULL_THR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= 6'd0;
         rd_ptr_q    <= 6'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         level_q     <= 6'd0;
         afull_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         level_q     <= level_d;
         afull_q     <= afull_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign level       = level_q;
   assign almost_full = afull_q;
   assign ovf         = ovf_q;
endmodule

// File: tb/tb_fifo32_sdp_ctrl.sv
// Bench for fifo32_sdp_ctrl: directed scenarios plus randomized traffic, compared against
// a queue-based model of RAM contents and the output register.

module tb_fifo32_sdp_ctrl;
   localparam int W  = 6;
   localparam int AF = 28;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic [5:0]   level;
   logic         almost_full;
   logic         ovf;

   int n_checks = 0;
   int n_pass   = 0;

   fifo32_sdp_ctrl #(.WIDTH(W), .AFULL_LVL(AF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .level       (level),
      .almost_full (almost_full),
      .ovf         (ovf)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // reference model: words held in RAM plus the output register
   logic [W-1:0] m_ram[$];
   bit           m_ov;
   logic [W-1:0] m_od;
   bit           m_ovf;
   // scoreboard: every accepted word, in order, until it leaves the block
   logic [W-1:0] exp_q[$];

   logic [W+9:0] dut_vec;
   assign dut_vec = {out_valid, out_data, level, almost_full, ovf, in_ready};

   function automatic logic [W+9:0] exp_vec();
      int occ;
      occ = m_ram.size();
      return {m_ov, m_od, 6'(occ + int'(m_ov)), (occ >= AF), m_ovf, (occ < 32)};
   endfunction

   task automatic model_reset();
      m_ram.delete();
      exp_q.delete();
      m_ov  = 1'b0;
      m_od  = '0;
      m_ovf = 1'b0;
   endtask

   task automatic model_edge(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
      bit can_take;
      if (fl) begin
         m_ram.delete();
         exp_q.delete();
         m_ov  = 1'b0;
         m_ovf = 1'b0;
      end else begin
         can_take = (m_ram.size() < 32);
         if (iv && !can_take) m_ovf = 1'b1;
         if ((!m_ov || ordy) && m_ram.size() > 0) begin
            m_od = m_ram.pop_front();
            m_ov = 1'b1;
         end else if (m_ov && ordy) begin
            m_ov = 1'b0;
         end
         if (iv && can_take) begin
            m_ram.push_back(d);
            exp_q.push_back(d);
         end
      end
   endtask

   // driver: apply inputs just after an edge, advance model, step to just after the next edge
   task automatic tick(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      model_edge(iv, d, ordy, fl);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (dut_vec !== {1'b0, {W{1'b0}}, 6'd0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_state got=%h exp=%h", dut_vec, {1'b0, {W{1'b0}}, 6'd0, 1'b0, 1'b0, 1'b1});
      else n_pass++;
      rst_n = 1'b1;
      tick(0, '0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_single();
      tick(0, '0, 0, 1);
      tick(1, 6'h15, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || level !== 6'd1)
         $display("FAIL single_edge1 got ov=%b lvl=%0d exp ov=0 lvl=1", out_valid, level);
      else n_pass++;
      tick(0, '0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 6'h15 || level !== 6'd1)
            $display("FAIL single_hold got ov=%b d=%h lvl=%0d exp ov=1 d=15 lvl=1", out_valid, out_data, level);
         else n_pass++;
         tick(0, '0, 0, 0);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL single_model got=%h exp=%h", dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_fill_overflow();
      int got;
      tick(0, '0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         tick(1, W'(i), 0, 0);
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL fill_step%0d got=%h exp=%h", i, dut_vec, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (level !== 6'd33 || ovf !== 1'b1 || in_ready !== 1'b0 || almost_full !== 1'b1)
         $display("FAIL fill_full got lvl=%0d ovf=%b rdy=%b af=%b exp lvl=33 ovf=1 rdy=0 af=1",
                  level, ovf, in_ready, almost_full);
      else n_pass++;
      got = 0;
      for (int i = 0; i < 40 && got < 33; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== W'(got))
            $display("FAIL drain_word%0d got ov=%b d=%0d exp ov=1 d=%0d", got, out_valid, out_data, got);
         else n_pass++;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         got++;
         tick(0, '0, 1, 0);
      end
      n_checks++;
      if (got !== 33 || out_valid !== 1'b0 || level !== 6'd0)
         $display("FAIL drain_end got n=%0d ov=%b lvl=%0d exp n=33 ov=0 lvl=0", got, out_valid, level);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int got;
      int bad_lvl;
      tick(0, '0, 0, 1);
      got = 0;
      bad_lvl = 0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid && got < 100) begin
            n_checks++;
            if (out_data !== W'(got)) $display("FAIL stream_word%0d got=%0d exp=%0d", got, out_data, W'(got));
            else n_pass++;
            got++;
         end
         tick(1, W'(i), 1, 0);
         if (level != 6'd1 && level != 6'd2) bad_lvl++;
      end
      for (int i = 0; i < 10 && got < 100; i++) begin
         if (out_valid) begin
            n_checks++;
            if (out_data !== W'(got)) $display("FAIL stream_word%0d got=%0d exp=%0d", got, out_data, W'(got));
            else n_pass++;
            got++;
         end
         tick(0, '0, 1, 0);
      end
      n_checks++;
      if (got !== 100 || bad_lvl !== 0)
         $display("FAIL stream_summary got n=%0d badlvl=%0d exp n=100 badlvl=0", got, bad_lvl);
      else n_pass++;
   endtask

   task automatic test_almost_full();
      tick(0, '0, 0, 1);
      for (int i = 0; i < 40 && m_ram.size() < AF; i++) begin
         tick(1, W'($urandom_range(0, 63)), 0, 0);
         n_checks++;
         if (almost_full !== (m_ram.size() >= AF))
            $display("FAIL afull_rise occ=%0d got=%b exp=%b", m_ram.size(), almost_full, m_ram.size() >= AF);
         else n_pass++;
      end
      n_checks++;
      if (almost_full !== 1'b1 || level !== 6'(AF + 1))
         $display("FAIL afull_at_thr got af=%b lvl=%0d exp af=1 lvl=%0d", almost_full, level, AF + 1);
      else n_pass++;
      tick(0, '0, 1, 0);
      n_checks++;
      if (almost_full !== 1'b0 || dut_vec !== exp_vec())
         $display("FAIL afull_fall got af=%b vec=%h exp af=0 vec=%h", almost_full, dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_flush();
      tick(0, '0, 0, 1);
      for (int i = 0; i < 10; i++) tick(1, W'(i + 7), 0, 0);
      n_checks++;
      if (level !== 6'd10) $display("FAIL flush_pre got lvl=%0d exp=10", level);
      else n_pass++;
      tick(1, 6'h3F, 0, 1);
      n_checks++;
      if (level !== 6'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_clear got lvl=%0d ov=%b ovf=%b rdy=%b exp 0 0 0 1", level, out_valid, ovf, in_ready);
      else n_pass++;
      tick(0, '0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || level !== 6'd0)
         $display("FAIL flush_dropped got ov=%b lvl=%0d exp ov=0 lvl=0", out_valid, level);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      tick(0, '0, 0, 1);
      for (int i = 0; i < 5; i++) tick(1, W'(i + 20), 0, 0);
      n_checks++;
      if (level !== 6'd5) $display("FAIL rstmid_pre got lvl=%0d exp=5", level);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (dut_vec !== {1'b0, {W{1'b0}}, 6'd0, 1'b0, 1'b0, 1'b1})
         $display("FAIL rstmid_async got=%h exp=%h", dut_vec, {1'b0, {W{1'b0}}, 6'd0, 1'b0, 1'b0, 1'b1});
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1, 6'h2A, 0, 0);
      tick(0, '0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 6'h2A || level !== 6'd1)
         $display("FAIL rstmid_push got ov=%b d=%h lvl=%0d exp ov=1 d=2a lvl=1", out_valid, out_data, level);
      else n_pass++;
   endtask

   task automatic test_random();
      bit iv, ordy, fl;
      tick(0, '0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         fl   = ($urandom_range(0, 79) == 0);
         if (out_valid && ordy && !fl) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL rand_sb_empty cyc=%0d got d=%h exp none", i, out_data);
            else if (out_data !== exp_q[0]) $display("FAIL rand_sb cyc=%0d got=%h exp=%h", i, out_data, exp_q[0]);
            else n_pass++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         tick(iv, W'($urandom_range(0, 63)), ordy, fl);
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL rand_state cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_back_to_back();
      test_almost_full();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
